// File: rtl/seg_scan_driver_p.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver_p
// Brief    : Parametrised multiplexed 7-segment scan driver. Loads a binary
//            value over a valid/busy handshake, converts it to BCD one bit
//            per cycle (or passes hex nibbles through), and time-multiplexes
//            DIGITS common-anode digits with leading-zero blanking, per-digit
//            blink, overflow dashes and selectable output polarity.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver_p #(
    parameter int DIGITS      = 6,
    parameter int VAL_W       = 20,
    parameter int SCAN_DIV    = 1000,
    parameter int BLINK_DIV   = 25_000_000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit SEL_ACT_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VAL_W-1:0]  value,
    input  logic              value_vld,
    input  logic              hex_mode,
    input  logic [DIGITS-1:0] dot,
    input  logic [DIGITS-1:0] blink,
    input  logic              blank_lz,
    output logic              busy,
    output logic [DIGITS-1:0] sel,
    output logic [7:0]        seg
);

    localparam int c_BCD_W   = 4 * DIGITS;
    localparam int c_EXT_W   = (VAL_W > c_BCD_W) ? VAL_W : c_BCD_W;
    localparam int c_CNT_W   = (VAL_W > 1) ? $clog2(VAL_W) : 1;
    localparam int c_IDX_W   = $clog2(DIGITS);
    localparam int c_SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [c_CNT_W-1:0]   c_BIT_LAST   = c_CNT_W'(VAL_W - 1);
    localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'(DIGITS - 1);
    localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);

    localparam logic [7:0]        c_SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] c_SEL_OFF = SEL_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_CONV = 1'b1;

    // Load / conversion state
    logic [0:0]           r_state;
    logic                 r_busy;
    logic                 r_hex;
    logic [VAL_W-1:0]     r_shift;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic                 r_ovf_acc;

    // Display buffer
    logic [c_BCD_W-1:0]   r_buf;
    logic                 r_ovf;

    // Scan / blink timing and registered outputs
    logic [c_SCAN_W-1:0]  r_scan_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink_phase;
    logic [DIGITS-1:0]    r_sel;
    logic [7:0]           r_seg;

    logic [c_BCD_W-1:0]   w_add3;
    logic [c_BCD_W-1:0]   w_dd_next;
    logic [c_EXT_W-1:0]   w_val_ext;
    logic [c_BCD_W-1:0]   w_hex;
    logic [DIGITS-1:0]    w_lz;
    logic                 w_scan_wrap;
    logic [3:0]           w_nib;
    logic                 w_dp_n;
    logic [7:0]           w_seg_low;
    logic [DIGITS-1:0]    w_onehot;

    // Common-anode glyphs, active-low, g..a in bits 6:0
    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    f_glyph = 7'h40;
            4'h1:    f_glyph = 7'h79;
            4'h2:    f_glyph = 7'h24;
            4'h3:    f_glyph = 7'h30;
            4'h4:    f_glyph = 7'h19;
            4'h5:    f_glyph = 7'h12;
            4'h6:    f_glyph = 7'h02;
            4'h7:    f_glyph = 7'h78;
            4'h8:    f_glyph = 7'h00;
            4'h9:    f_glyph = 7'h10;
            4'hA:    f_glyph = 7'h08;
            4'hB:    f_glyph = 7'h03;
            4'hC:    f_glyph = 7'h46;
            4'hD:    f_glyph = 7'h21;
            4'hE:    f_glyph = 7'h06;
            default: f_glyph = 7'h0E;
        endcase
    endfunction

    // Per-digit helpers: double-dabble correction and "this digit and all
    // above are zero" flags for leading-zero blanking.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign w_add3[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? (r_bcd[4*i +: 4] + 4'd3)
                                                            : r_bcd[4*i +: 4];
        assign w_lz[i] = (r_buf[c_BCD_W-1:4*i] == '0);
    end

    // The bit shifted out of the top nibble would start digit DIGITS, so any
    // 1 leaving the register means the value needs more digits than we have.
    assign w_dd_next = {w_add3[c_BCD_W-2:0], r_shift[VAL_W-1]};
    assign w_val_ext = c_EXT_W'(r_shift);
    assign w_hex     = w_val_ext[c_BCD_W-1:0];

    // Load FSM: accept in IDLE, run VAL_W dabble steps (or one hex step)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_busy    <= 1'b0;
            r_hex     <= 1'b0;
            r_shift   <= '0;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
            r_ovf_acc <= 1'b0;
            r_buf     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (value_vld && !r_busy) begin
                        r_shift   <= value;
                        r_hex     <= hex_mode;
                        r_bcd     <= '0;
                        r_bit_cnt <= '0;
                        r_ovf_acc <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= c_ST_CONV;
                    end
                end
                c_ST_CONV: begin
                    if (r_hex) begin
                        r_buf   <= w_hex;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_bcd     <= w_dd_next;
                        r_shift   <= r_shift << 1;
                        r_ovf_acc <= r_ovf_acc | w_add3[c_BCD_W-1];
                        r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_buf   <= w_dd_next;
                            r_ovf   <= r_ovf_acc | w_add3[c_BCD_W-1];
                            r_busy  <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Blink phase generator, toggles every BLINK_DIV cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
        end
    end

    assign w_scan_wrap = (r_scan_cnt == c_SCAN_LAST);
    assign w_nib       = r_buf[{r_idx, 2'b00} +: 4];
    assign w_dp_n      = ~dot[r_idx];
    assign w_onehot    = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;

    // Active-low segment byte for the digit about to be driven, by priority
    always_comb begin
        w_seg_low = 8'hFF;
        if (r_blink_phase && blink[r_idx]) begin
            w_seg_low = 8'hFF;
        end else if (r_ovf) begin
            w_seg_low = {w_dp_n, 7'h3F};
        end else if (blank_lz && (r_idx != '0) && w_lz[r_idx]) begin
            w_seg_low = {w_dp_n, 7'h7F};
        end else begin
            w_seg_low = {w_dp_n, f_glyph(w_nib)};
        end
    end

    // Scan counter and digit index; sel and seg load together on the wrap
    // edge so they always describe the same digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_sel      <= c_SEL_OFF;
            r_seg      <= c_SEG_OFF;
        end else if (w_scan_wrap) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == c_IDX_LAST) ? '0 : (r_idx + c_IDX_W'(1));
            r_sel      <= SEL_ACT_LOW ? ~w_onehot : w_onehot;
            r_seg      <= SEG_ACT_LOW ? w_seg_low : ~w_seg_low;
        end else begin
            r_scan_cnt <= r_scan_cnt + c_SCAN_W'(1);
        end
    end

    assign busy = r_busy;
    assign sel  = r_sel;
    assign seg  = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver_p.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver_p
// Brief    : Self-checking bench for seg_scan_driver_p. A digit-level model
//            (decimal / hex digit extraction, glyph table, blanking rules)
//            predicts sel/seg at every scan slot.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver_p;

    localparam int DIGITS    = 6;
    localparam int VAL_W     = 20;
    localparam int SCAN_DIV  = 100;
    localparam int BLINK_DIV = 700;
    localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{1'b1}};

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic [VAL_W-1:0]  value     = '0;
    logic              value_vld = 1'b0;
    logic              hex_mode  = 1'b0;
    logic [DIGITS-1:0] dot       = '0;
    logic [DIGITS-1:0] blink     = '0;
    logic              blank_lz  = 1'b0;
    logic              busy;
    logic [DIGITS-1:0] sel;
    logic [7:0]        seg;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt;

    // Reference model of the display buffer, digit by digit
    int m_nib [DIGITS];
    bit m_ovf = 1'b0;
    int m_top = 0;

    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_scan_driver_p #(
        .DIGITS      (DIGITS),
        .VAL_W       (VAL_W),
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_DIV   (BLINK_DIV),
        .SEG_ACT_LOW (1'b1),
        .SEL_ACT_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .value_vld (value_vld),
        .hex_mode  (hex_mode),
        .dot       (dot),
        .blink     (blink),
        .blank_lz  (blank_lz),
        .busy      (busy),
        .sel       (sel),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic model_load(input logic [VAL_W-1:0] v, input bit hx);
        longint lv;
        longint pw;
        lv    = longint'(v);
        m_ovf = 1'b0;
        pw    = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (hx) m_nib[i] = int'((lv >> (4 * i)) & 64'd15);
            else    m_nib[i] = int'((lv / pw) % 10);
            pw = pw * 10;
        end
        if (!hx && lv >= pw) m_ovf = 1'b1;
        m_top = 0;
        for (int i = 0; i < DIGITS; i++)
            if (m_nib[i] != 0) m_top = i;
    endtask

    function automatic logic [DIGITS-1:0] exp_sel(input int d);
        logic [DIGITS-1:0] oh;
        oh    = '0;
        oh[d] = 1'b1;
        return ~oh;
    endfunction

    function automatic logic [7:0] exp_seg(input int d, input int ph);
        logic       dpn;
        logic [7:0] g;
        dpn = ~dot[d];
        if (ph == 1 && blink[d]) return 8'hFF;
        if (m_ovf) return {dpn, 7'h3F};
        if (blank_lz && d > 0 && d > m_top) return {dpn, 7'h7F};
        g = glyph_tab[m_nib[d]];
        return {dpn, g[6:0]};
    endfunction

    // Watch nwraps scan slots, comparing each against the model and once more
    // mid-slot to confirm the outputs hold between wraps.
    task automatic check_scan(input string tag, input int nwraps);
        int seen, guard, d, ph;
        logic [DIGITS-1:0] esel;
        logic [7:0]        eseg;
        seen  = 0;
        guard = 0;
        esel  = SEL_OFF;
        eseg  = 8'hFF;
        while (seen < nwraps && guard < (nwraps + 1) * SCAN_DIV + 10) begin
            @(negedge clk);
            guard++;
            if (edge_cnt > 0 && edge_cnt % SCAN_DIV == 0) begin
                d    = (edge_cnt / SCAN_DIV - 1) % DIGITS;
                ph   = ((edge_cnt - 1) / BLINK_DIV) % 2;
                esel = exp_sel(d);
                eseg = exp_seg(d, ph);
                n_checks++;
                if (sel !== esel || seg !== eseg) begin
                    n_fail++;
                    $display("FAIL %s digit %0d: sel=%b seg=%h, expected sel=%b seg=%h",
                             tag, d, sel, seg, esel, eseg);
                end
                seen++;
            end else if (seen > 0 && edge_cnt % SCAN_DIV == SCAN_DIV / 2) begin
                n_checks++;
                if (sel !== esel || seg !== eseg) begin
                    n_fail++;
                    $display("FAIL %s hold: sel=%b seg=%h, expected sel=%b seg=%h",
                             tag, sel, seg, esel, eseg);
                end
            end
        end
        if (seen < nwraps) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scan timeout: %0d of %0d slots seen", tag, seen, nwraps);
        end
    endtask

    task automatic do_load(input logic [VAL_W-1:0] v, input bit hx, input string tag);
        int          n;
        logic [31:0] rnd;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy before load: got %b, expected 0", tag, busy);
        end
        value     = v;
        hex_mode  = hx;
        value_vld = 1'b1;
        @(negedge clk);
        value_vld = 1'b0;
        rnd       = $urandom;
        value     = rnd[VAL_W-1:0];
        hex_mode  = ~hx;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != (hx ? 1 : VAL_W)) begin
            n_fail++;
            $display("FAIL %s busy length: got %0d cycles, expected %0d", tag, n, hx ? 1 : VAL_W);
        end
        model_load(v, hx);
    endtask

    task automatic test_reset;
        model_load('0, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || sel !== SEL_OFF || seg !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b sel=%b seg=%h, expected busy=0 sel=%b seg=ff",
                     busy, sel, seg, SEL_OFF);
        end
        rst = 1'b0;
        while (edge_cnt < SCAN_DIV - 1) @(negedge clk);
        n_checks++;
        if (sel !== SEL_OFF || seg !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_early_drive: sel=%b seg=%h, expected sel=%b seg=ff", sel, seg, SEL_OFF);
        end
        check_scan("reset_scan", DIGITS);
    endtask

    task automatic test_decimal;
        dot = '0; blink = '0; blank_lz = 1'b0;
        do_load(20'd123456, 1'b0, "dec_123456");
        check_scan("dec_123456", DIGITS);
    endtask

    task automatic test_lz;
        dot = 6'b000100; blink = '0;
        blank_lz = 1'b1;
        do_load(20'd42, 1'b0, "lz_42");
        check_scan("lz_42_on", DIGITS);
        blank_lz = 1'b0;
        check_scan("lz_42_off", DIGITS);
        blank_lz = 1'b1; dot = 6'b100001;
        do_load(20'd0, 1'b0, "lz_zero");
        check_scan("lz_zero", DIGITS);
    endtask

    task automatic test_hex;
        dot = '0; blink = '0; blank_lz = 1'b0;
        do_load(20'hABCDE, 1'b1, "hex_abcde");
        check_scan("hex_abcde", DIGITS);
    endtask

    task automatic test_overflow;
        dot = 6'b010000; blink = '0; blank_lz = 1'b1;
        do_load(20'd1000000, 1'b0, "ovf_1e6");
        check_scan("ovf_1e6", DIGITS);
        do_load(20'd999999, 1'b0, "max_999999");
        check_scan("max_999999", DIGITS);
        dot = '0; blank_lz = 1'b0;
        do_load(20'd7, 1'b0, "after_ovf_7");
        check_scan("after_ovf_7", DIGITS);
    endtask

    task automatic test_random;
        logic [31:0] rnd;
        logic [31:0] rv;
        for (int k = 0; k < 5; k++) begin
            rnd      = $urandom;
            rv       = $urandom;
            dot      = rnd[DIGITS-1:0];
            blank_lz = rnd[8];
            blink    = '0;
            do_load(rv[VAL_W-1:0], rnd[9], "rand_load");
            check_scan("rand_scan", DIGITS);
        end
    endtask

    task automatic test_blink;
        logic [31:0] rnd;
        rnd      = $urandom;
        blink    = rnd[DIGITS-1:0] | 6'b000001;
        dot      = rnd[DIGITS+7:8];
        blank_lz = 1'b0;
        do_load(20'd654321, 1'b0, "blink_load");
        check_scan("blink", 4 * DIGITS);
        blink = '0;
    endtask

    task automatic test_busy_drop;
        int n, guard, d, ph;
        bit saw_mid;
        dot = '0; blink = '0; blank_lz = 1'b0;
        do_load(20'd13579, 1'b0, "drop_first");
        check_scan("drop_first", DIGITS);
        guard = 0;
        while (edge_cnt % SCAN_DIV != SCAN_DIV - 8 && guard < 2 * SCAN_DIV) begin
            @(negedge clk);
            guard++;
        end
        value = 20'd86420; hex_mode = 1'b0; value_vld = 1'b1;
        @(negedge clk);
        value    = 20'd99999;
        hex_mode = 1'b1;
        n = 0;
        saw_mid = 1'b0;
        while (busy === 1'b1 && n < 200) begin
            if (edge_cnt % SCAN_DIV == 0) begin
                saw_mid = 1'b1;
                d  = (edge_cnt / SCAN_DIV - 1) % DIGITS;
                ph = ((edge_cnt - 1) / BLINK_DIV) % 2;
                n_checks++;
                if (sel !== exp_sel(d) || seg !== exp_seg(d, ph)) begin
                    n_fail++;
                    $display("FAIL buffer_hold_during_conv: sel=%b seg=%h, expected sel=%b seg=%h",
                             sel, seg, exp_sel(d), exp_seg(d, ph));
                end
            end
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != VAL_W || !saw_mid) begin
            n_fail++;
            $display("FAIL busy_with_vld_held: busy %0d cycles mid_wrap=%0d, expected %0d cycles mid_wrap=1",
                     n, saw_mid, VAL_W);
        end
        value_vld = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL vld_at_busy_fall: busy=%b, expected 0", busy);
        end
        model_load(20'd86420, 1'b0);
        check_scan("drop_result", DIGITS);
    endtask

    task automatic test_reset_mid;
        dot = '0; blink = '0; blank_lz = 1'b0;
        @(negedge clk);
        value = 20'd987654; hex_mode = 1'b0; value_vld = 1'b1;
        @(negedge clk);
        value_vld = 1'b0;
        repeat (9) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_conv_busy: busy=%b, expected 1", busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || sel !== SEL_OFF || seg !== 8'hFF) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b sel=%b seg=%h, expected busy=0 sel=%b seg=ff",
                     busy, sel, seg, SEL_OFF);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_load('0, 1'b0);
        check_scan("after_reset_mid", DIGITS);
    endtask

    initial begin
        test_reset();
        test_decimal();
        test_lz();
        test_hex();
        test_overflow();
        test_random();
        test_blink();
        test_busy_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
